// File: rtl/dl_object_writer.sv
// Purpose: walks one zone's display list, decodes 4/5-byte object headers and streams each object's graphics bytes to the line RAM.
// Latency: one cycle per accepted header byte, one LOAD cycle, then FETCH (>=1 cycle, until GFX_VALID) + WRITE per graphics byte.
// Backpressure: DL_VALID/DL_READY handshake on list bytes; GFX_REQ is held with a stable address until GFX_VALID.
module dl_object_writer (
  input  logic        SYSCLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [3:0]  OFFSET,
  input  logic [7:0]  DL_DATA,
  input  logic        DL_VALID,
  output logic        DL_READY,
  output logic [15:0] GFX_ADDR,
  output logic        GFX_REQ,
  input  logic [7:0]  GFX_DATA,
  input  logic        GFX_VALID,
  output logic [7:0]  INPUT_ADDR,
  output logic        INPUT_W,
  output logic [2:0]  PALETTE,
  output logic        PALETTE_W,
  output logic        WM,
  output logic        WM_W,
  output logic [7:0]  PIXELS,
  output logic        PIXELS_W,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [3:0] {
    IDLE, H0, H1, H2, H3, H4, LOAD, FETCH, WRITE, END
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_lo_q, addr_lo_d;
  logic [7:0]  addr_hi_q, addr_hi_d;
  logic [2:0]  hdr_pal_q, hdr_pal_d;
  logic [4:0]  width_q, width_d;
  logic        hdr_wm_q, hdr_wm_d;
  logic        five_q, five_d;
  logic [5:0]  count_q, count_d;
  logic [15:0] gfx_addr_q, gfx_addr_d;
  logic        gfx_req_q, gfx_req_d;
  logic [7:0]  input_addr_q, input_addr_d;
  logic        input_w_q, input_w_d;
  logic [2:0]  palette_q, palette_d;
  logic        palette_w_q, palette_w_d;
  logic        wm_q, wm_d;
  logic        wm_w_q, wm_w_d;
  logic [7:0]  pixels_q, pixels_d;
  logic        pixels_w_q, pixels_w_d;
  logic        done_q, done_d;

  logic        dl_fire;
  logic        load_now;

  assign DL_READY   = (state_q == H0) || (state_q == H1) || (state_q == H2) ||
                      (state_q == H3) || (state_q == H4);
  assign BUSY       = (state_q != IDLE);
  assign dl_fire    = DL_VALID && DL_READY;

  assign GFX_ADDR   = gfx_addr_q;
  assign GFX_REQ    = gfx_req_q;
  assign INPUT_ADDR = input_addr_q;
  assign INPUT_W    = input_w_q;
  assign PALETTE    = palette_q;
  assign PALETTE_W  = palette_w_q;
  assign WM         = wm_q;
  assign WM_W       = wm_w_q;
  assign PIXELS     = pixels_q;
  assign PIXELS_W   = pixels_w_q;
  assign DONE       = done_q;

  // Next-state and next-output decode; strobes are computed one cycle ahead so they leave as flops.
  always_comb begin
    state_d      = state_q;
    addr_lo_d    = addr_lo_q;
    addr_hi_d    = addr_hi_q;
    hdr_pal_d    = hdr_pal_q;
    width_d      = width_q;
    hdr_wm_d     = hdr_wm_q;
    five_d       = five_q;
    count_d      = count_q;
    gfx_addr_d   = gfx_addr_q;
    gfx_req_d    = 1'b0;
    input_addr_d = input_addr_q;
    input_w_d    = 1'b0;
    palette_d    = palette_q;
    palette_w_d  = 1'b0;
    wm_d         = wm_q;
    wm_w_d       = 1'b0;
    pixels_d     = pixels_q;
    pixels_w_d   = 1'b0;
    done_d       = 1'b0;
    load_now     = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) state_d = H0;
      end
      H0: begin
        if (dl_fire) begin
          addr_lo_d = DL_DATA;
          state_d   = H1;
        end
      end
      H1: begin
        if (dl_fire) begin
          if (DL_DATA[4:0] != 5'd0) begin
            hdr_pal_d = DL_DATA[7:5];
            width_d   = DL_DATA[4:0];
            five_d    = 1'b0;
            state_d   = H2;
          end else if (DL_DATA[6]) begin
            // Extended header: bit 7 carries write mode, palette/width follow in byte 3.
            hdr_wm_d  = DL_DATA[7];
            five_d    = 1'b1;
            state_d   = H2;
          end else begin
            done_d    = 1'b1;
            state_d   = END;
          end
        end
      end
      H2: begin
        if (dl_fire) begin
          addr_hi_d = DL_DATA;
          state_d   = H3;
        end
      end
      H3: begin
        if (dl_fire) begin
          if (five_q) begin
            hdr_pal_d = DL_DATA[7:5];
            width_d   = DL_DATA[4:0];
            state_d   = H4;
          end else begin
            load_now  = 1'b1;
          end
        end
      end
      H4: begin
        if (dl_fire) load_now = 1'b1;
      end
      LOAD: begin
        gfx_req_d = 1'b1;
        state_d   = FETCH;
      end
      FETCH: begin
        if (GFX_VALID) begin
          pixels_d   = GFX_DATA;
          pixels_w_d = 1'b1;
          state_d    = WRITE;
        end else begin
          gfx_req_d  = 1'b1;
        end
      end
      WRITE: begin
        count_d = count_q - 6'd1;
        if (count_q == 6'd1) begin
          state_d = H0;
        end else begin
          gfx_addr_d = gfx_addr_q + 16'd1;
          gfx_req_d  = 1'b1;
          state_d    = FETCH;
        end
      end
      END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Last header byte is the horizontal position; everything else is already latched.
    if (load_now) begin
      input_addr_d = DL_DATA;
      input_w_d    = 1'b1;
      palette_d    = (five_q && state_q == H3) ? DL_DATA[7:5] : hdr_pal_q;
      palette_w_d  = 1'b1;
      if (five_q) begin
        wm_d   = hdr_wm_q;
        wm_w_d = 1'b1;
      end
      // Width 0 encodes a full 32-byte object.
      count_d    = 6'd32 - {1'b0, width_q};
      gfx_addr_d = {addr_hi_q + {4'd0, OFFSET}, addr_lo_q};
      state_d    = LOAD;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      addr_lo_q    <= 8'd0;
      addr_hi_q    <= 8'd0;
      hdr_pal_q    <= 3'd0;
      width_q      <= 5'd0;
      hdr_wm_q     <= 1'b0;
      five_q       <= 1'b0;
      count_q      <= 6'd0;
      gfx_addr_q   <= 16'd0;
      gfx_req_q    <= 1'b0;
      input_addr_q <= 8'd0;
      input_w_q    <= 1'b0;
      palette_q    <= 3'd0;
      palette_w_q  <= 1'b0;
      wm_q         <= 1'b0;
      wm_w_q       <= 1'b0;
      pixels_q     <= 8'd0;
      pixels_w_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_lo_q    <= addr_lo_d;
      addr_hi_q    <= addr_hi_d;
      hdr_pal_q    <= hdr_pal_d;
      width_q      <= width_d;
      hdr_wm_q     <= hdr_wm_d;
      five_q       <= five_d;
      count_q      <= count_d;
      gfx_addr_q   <= gfx_addr_d;
      gfx_req_q    <= gfx_req_d;
      input_addr_q <= input_addr_d;
      input_w_q    <= input_w_d;
      palette_q    <= palette_d;
      palette_w_q  <= palette_w_d;
      wm_q         <= wm_d;
      wm_w_q       <= wm_w_d;
      pixels_q     <= pixels_d;
      pixels_w_q   <= pixels_w_d;
      done_q       <= done_d;
    end
  end

endmodule
